// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates conditional branches, JAL and JALR,
// compares the outcome with the fetch-stage static prediction, and issues a
// registered redirect (or misalignment exception) followed by a multi-cycle flush
// of the younger stages. Also keeps saturating branch and mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_STAGES = 1,
    parameter int unsigned PREDICT_MODE = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_instr_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StFlush = 1'b1;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    // Flush cycles remaining after the first one; FLUSH_STAGES is limited to 1..7.
    localparam logic [2:0] FlushInit = 3'(FLUSH_STAGES - 1);

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_ct;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;

    assign opcode  = ex_instr_i[6:0];
    assign funct3  = ex_instr_i[14:12];
    assign is_jal  = (opcode == OpJal);
    assign is_jalr = (opcode == OpJalr);

    assign imm_b = {{(XLEN-13){ex_instr_i[31]}}, ex_instr_i[31], ex_instr_i[7],
                    ex_instr_i[30:25], ex_instr_i[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ex_instr_i[31]}}, ex_instr_i[31], ex_instr_i[19:12],
                    ex_instr_i[20], ex_instr_i[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){ex_instr_i[31]}}, ex_instr_i[31:20]};

    // ------------------------------------------------------------------------
    // Branch condition evaluation
    // ------------------------------------------------------------------------
    logic op_eq;
    logic op_lt_s;
    logic op_lt_u;
    logic br_cond;
    logic br_f3_ok;

    assign op_eq   = (rs1_data_i == rs2_data_i);
    assign op_lt_s = ($signed(rs1_data_i) < $signed(rs2_data_i));
    assign op_lt_u = (rs1_data_i < rs2_data_i);

    // Select the compare result by funct3; 010/011 are not branches at all.
    always_comb begin
        br_cond  = 1'b0;
        br_f3_ok = 1'b1;
        case (funct3)
            3'b000:  br_cond = op_eq;
            3'b001:  br_cond = ~op_eq;
            3'b100:  br_cond = op_lt_s;
            3'b101:  br_cond = ~op_lt_s;
            3'b110:  br_cond = op_lt_u;
            3'b111:  br_cond = ~op_lt_u;
            default: br_f3_ok = 1'b0;
        endcase
    end

    assign is_branch = (opcode == OpBranch) & br_f3_ok;
    assign is_ct     = is_branch | is_jal | is_jalr;

    // ------------------------------------------------------------------------
    // Target, outcome and mispredict detection
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fix_pc;
    logic            taken;
    logic            pred_taken;
    logic            need_redirect;
    logic            bad_target;

    assign jalr_sum = rs1_data_i + imm_i;

    // Pick the target for the decoded transfer type (all arithmetic wraps).
    always_comb begin
        target = ex_pc_i + imm_b;
        if (is_jal) begin
            target = ex_pc_i + imm_j;
        end else if (is_jalr) begin
            target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        end
    end

    assign taken      = is_jal | is_jalr | (is_branch & br_cond);
    assign pred_taken = (PREDICT_MODE != 0) ? ex_pred_taken_i : 1'b0;

    // A predicted-taken JALR still redirects: fetch cannot know a register target.
    assign need_redirect = taken ? (~pred_taken | is_jalr) : pred_taken;
    assign bad_target    = taken & (target[1:0] != 2'b00);
    assign fix_pc        = taken ? target : (ex_pc_i + XLEN'(4));

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic resolve;
    logic act;

    // EX is only looked at in IDLE; during FLUSH it holds squashed work.
    assign resolve = (state_q == StIdle) & ex_valid_i & is_ct;
    assign act     = resolve & (need_redirect | bad_target);

    // Next-state logic: FSM, pulse outputs, flush down-counter and perf counters.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        flush_d          = flush_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = 1'b0;
        misalign_addr_d  = misalign_addr_q;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;

        case (state_q)
            StIdle: begin
                if (act) begin
                    state_d = StFlush;
                    cnt_d   = FlushInit;
                    flush_d = 1'b1;
                    if (bad_target) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = target;
                    end else begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = fix_pc;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                flush_d = 1'b0;
            end
        endcase

        if (resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (redirect_valid_d && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // Register all state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            cnt_q            <= 3'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            misalign_addr_q  <= '0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            misalign_addr_q  <= misalign_addr_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign misalign_o       = misalign_q;
    assign misalign_addr_o  = misalign_addr_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit. Two instances share one stimulus
// stream: dut0 uses the defaults (1-cycle flush, not-taken prediction, 16-bit
// counters); dut1 uses a 3-cycle flush, BTFN prediction and 2-bit counters.
module tb_branch_resolve_unit;

    localparam int KNone = 0;
    localparam int KBr   = 1;
    localparam int KJal  = 2;
    localparam int KJalr = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;

    logic        rv0, fl0, mis0;
    logic [31:0] rpc0, ma0;
    logic [15:0] bc0, mc0;
    logic        rv1, fl1, mis1;
    logic [31:0] rpc1, ma1;
    logic [1:0]  bc1, mc1;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN(32), .FLUSH_STAGES(1), .PREDICT_MODE(0), .CNT_W(16)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_instr_i(instr),
        .ex_pc_i(pc), .ex_pred_taken_i(pred), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .redirect_valid_o(rv0), .redirect_pc_o(rpc0), .flush_o(fl0),
        .misalign_o(mis0), .misalign_addr_o(ma0),
        .branch_cnt_o(bc0), .mispred_cnt_o(mc0)
    );

    branch_resolve_unit #(
        .XLEN(32), .FLUSH_STAGES(3), .PREDICT_MODE(1), .CNT_W(2)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_instr_i(instr),
        .ex_pc_i(pc), .ex_pred_taken_i(pred), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .redirect_valid_o(rv1), .redirect_pc_o(rpc1), .flush_o(fl1),
        .misalign_o(mis1), .misalign_addr_o(ma1),
        .branch_cnt_o(bc1), .mispred_cnt_o(mc1)
    );

    typedef struct {
        bit          rv;
        bit          mis;
        logic [31:0] addr;
        int          due;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int fs_p[2]   = '{1, 3};
    int mode_p[2] = '{0, 1};
    int max_p[2]  = '{65535, 3};

    // Model state: cycles of EX still being ignored, and expected flush/counters.
    int ign[2]  = '{0, 0};
    bit e_fl[2] = '{0, 0};
    int e_bc[2] = '{0, 0};
    int e_mc[2] = '{0, 0};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] encode(int kind, logic [2:0] f3, int imm);
        logic [31:0] im;
        logic [31:0] fill;
        im   = imm;
        fill = $urandom;
        case (kind)
            KBr:     return {im[12], im[10:5], fill[24:20], fill[19:15], f3, im[4:1], im[11],
                             7'b1100011};
            KJal:    return {im[20], im[10:1], im[11], im[19:12], fill[11:7], 7'b1101111};
            KJalr:   return {im[11:0], fill[19:15], 3'b000, fill[11:7], 7'b1100111};
            default: return {fill[31:7], 7'b0110011};
        endcase
    endfunction

    // Reference model for one instance, working from the intended immediate.
    task automatic model(int i, bit r, bit v, int kind, logic [2:0] f3, int imm,
                         logic [31:0] p, logic [31:0] a, logic [31:0] b, bit pr);
        bit          ct, tk, pe, need, mis;
        logic [31:0] tgt;
        ev_t         e;
        if (!r) begin
            ign[i] = 0; e_fl[i] = 0; e_bc[i] = 0; e_mc[i] = 0;
            return;
        end
        if (ign[i] > 0) begin
            ign[i]--;
            e_fl[i] = (ign[i] > 0);
            return;
        end
        e_fl[i] = 0;
        ct = v && (kind == KJal || kind == KJalr || (kind == KBr && f3 != 2 && f3 != 3));
        if (!ct) return;
        tk  = 1;
        tgt = p + 32'(imm);
        if (kind == KBr) begin
            case (f3)
                3'd0:    tk = (a == b);
                3'd1:    tk = (a != b);
                3'd4:    tk = ($signed(a) < $signed(b));
                3'd5:    tk = ($signed(a) >= $signed(b));
                3'd6:    tk = (a < b);
                default: tk = (a >= b);
            endcase
        end else if (kind == KJalr) begin
            tgt = (a + 32'(imm)) & 32'hFFFF_FFFE;
        end
        pe   = (mode_p[i] != 0) && pr;
        need = tk ? (!pe || kind == KJalr) : pe;
        mis  = tk && (tgt[1:0] != 2'b00);
        if (e_bc[i] < max_p[i]) e_bc[i]++;
        if (need || mis) begin
            e.rv   = !mis;
            e.mis  = mis;
            e.addr = (mis || tk) ? tgt : p + 32'd4;
            e.due  = cyc + 1;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            if (!mis && e_mc[i] < max_p[i]) e_mc[i]++;
            ign[i]  = fs_p[i];
            e_fl[i] = 1;
        end
    endtask

    // Present one cycle of EX input and record what both instances should do.
    task automatic step(bit r, bit v, int kind, logic [2:0] f3, int imm,
                        logic [31:0] p, logic [31:0] a, logic [31:0] b, bit pr);
        @(posedge clk);
        #3;
        rst_n    = r;
        ex_valid = v;
        instr    = encode(kind, f3, imm);
        pc       = p;
        rs1      = a;
        rs2      = b;
        pred     = pr;
        for (int i = 0; i < 2; i++) model(i, r, v, kind, f3, imm, p, a, b, pr);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1, 0, KNone, 3'd0, 0, 32'd0, 32'd0, 32'd0, 0);
    endtask

    task automatic mon(int i, logic rv, logic mis, logic [31:0] rpc, logic [31:0] ma,
                       logic fl, logic [31:0] bc, logic [31:0] mc);
        ev_t e;
        bit  have;
        have = 0;
        if (i == 0) begin
            if (q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); have = 1; end
        end else begin
            if (q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); have = 1; end
        end
        if (have) begin
            chk($sformatf("dut%0d redirect_valid", i), 32'(rv), 32'(e.rv));
            chk($sformatf("dut%0d misalign", i), 32'(mis), 32'(e.mis));
            if (e.rv)  chk($sformatf("dut%0d redirect_pc", i), rpc, e.addr);
            if (e.mis) chk($sformatf("dut%0d misalign_addr", i), ma, e.addr);
        end else begin
            chk($sformatf("dut%0d no_pulse", i), {30'd0, rv, mis}, 32'd0);
        end
        chk($sformatf("dut%0d flush", i), 32'(fl), 32'(e_fl[i]));
        chk($sformatf("dut%0d branch_cnt", i), bc, 32'(e_bc[i]));
        chk($sformatf("dut%0d mispred_cnt", i), mc, 32'(e_mc[i]));
    endtask

    // Monitor: sample just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mon(0, rv0, mis0, rpc0, ma0, fl0, 32'(bc0), 32'(mc0));
            mon(1, rv1, mis1, rpc1, ma1, fl1, 32'(bc1), 32'(mc1));
        end
    end

    initial begin
        int          kind, imm;
        logic [2:0]  f3;
        logic [31:0] p, a, b, t;
        bit          r, v, pr;

        rst_n = 1'b0; ex_valid = 1'b0; instr = '0; pc = '0; rs1 = '0; rs2 = '0; pred = 1'b0;

        // Reset held with a taken BEQ in EX.
        step(0, 1, KBr, 3'd0, 16, 32'h100, 32'd5, 32'd5, 0);
        step(0, 1, KBr, 3'd0, 16, 32'h100, 32'd5, 32'd5, 0);
        idle(2);
        // Signed vs unsigned less-than on the same operands.
        step(1, 1, KBr, 3'd4, 16, 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
        idle(4);
        step(1, 1, KBr, 3'd6, 16, 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
        idle(4);
        // Backward BNE predicted taken: not taken, then taken.
        step(1, 1, KBr, 3'd1, -8, 32'h200, 32'd7, 32'd7, 1);
        idle(4);
        step(1, 1, KBr, 3'd1, -8, 32'h200, 32'd7, 32'd8, 1);
        idle(4);
        // JALR to a misaligned target.
        step(1, 1, KJalr, 3'd0, 0, 32'h300, 32'h1003, 32'd0, 0);
        idle(4);
        // JAL followed by mispredicting branches inside and just after the flush.
        step(1, 1, KJal, 3'd0, 64, 32'h300, 32'd0, 32'd0, 0);
        for (int k = 0; k < 4; k++) step(1, 1, KBr, 3'd4, 32, 32'h400, 32'hFFFF_FFFF, 32'd1, 0);
        idle(4);
        // Counter saturation.
        for (int k = 0; k < 5; k++) begin
            step(1, 1, KJal, 3'd0, 8, 32'h500, 32'd0, 32'd0, 0);
            idle(4);
        end
        // Reset in the middle of a flush.
        step(1, 1, KJal, 3'd0, 8, 32'h600, 32'd0, 32'd0, 0);
        step(0, 0, KNone, 3'd0, 0, 32'd0, 32'd0, 32'd0, 0);
        idle(4);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            kind = int'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            case (kind)
                KBr:     imm = int'($urandom_range(0, 4095)) * 2 - 4096;
                KJal:    imm = int'($urandom_range(0, 1048575)) * 2 - 1048576;
                default: imm = int'($urandom_range(0, 4095)) - 2048;
            endcase
            t = $urandom;
            p = {t[31:2], 2'b00};
            b = $urandom;
            case ($urandom_range(0, 3))
                0:       a = b;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            pr = 1'($urandom_range(0, 1));
            step(r, v, kind, f3, imm, p, a, b, pr);
        end
        idle(6);
        @(posedge clk);
        #2;
        chk("pending_events", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
